// File: rtl/memory_request_arbiter_pkg.sv
// Shared types for the instruction/data memory request arbiter.
package memory_arbiter_params;

  typedef enum logic {SOURCE_INST, SOURCE_DATA} source_id_t;

  typedef enum logic {IDLE, HOLD} arbiter_state_t;

  typedef struct packed {
    logic        request;
    logic        write;
    logic [1:0]  size;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [3:0]  write_strobe;
  } memory_request_t;

  localparam int OUTSTANDING_DEPTH_DEFAULT = 4;

endpackage

// File: rtl/memory_request_arbiter_if.sv
// Requester, memory-port and status signals of the arbiter; slave = arbiter side.
interface memory_request_arbiter_if;
  logic        inst_request, inst_write;
  logic [1:0]  inst_size;
  logic [31:0] inst_address, inst_write_data;
  logic [3:0]  inst_write_strobe;
  logic        inst_address_ready, inst_data_ok;
  logic [31:0] inst_read_data;

  logic        data_request, data_write;
  logic [1:0]  data_size;
  logic [31:0] data_address, data_write_data;
  logic [3:0]  data_write_strobe;
  logic        data_address_ready, data_data_ok;
  logic [31:0] data_read_data;

  logic        mem_request, mem_write;
  logic [1:0]  mem_size;
  logic [31:0] mem_address, mem_write_data;
  logic [3:0]  mem_write_strobe;
  logic        mem_address_ready, mem_data_ok;
  logic [31:0] mem_read_data;

  logic        protocol_error;

  modport slave (
    input  inst_request, inst_write, inst_size, inst_address, inst_write_data, inst_write_strobe,
    output inst_address_ready, inst_data_ok, inst_read_data,
    input  data_request, data_write, data_size, data_address, data_write_data, data_write_strobe,
    output data_address_ready, data_data_ok, data_read_data,
    output mem_request, mem_write, mem_size, mem_address, mem_write_data, mem_write_strobe,
    input  mem_address_ready, mem_data_ok, mem_read_data,
    output protocol_error
  );

  modport master (
    output inst_request, inst_write, inst_size, inst_address, inst_write_data, inst_write_strobe,
    input  inst_address_ready, inst_data_ok, inst_read_data,
    output data_request, data_write, data_size, data_address, data_write_data, data_write_strobe,
    input  data_address_ready, data_data_ok, data_read_data,
    input  mem_request, mem_write, mem_size, mem_address, mem_write_data, mem_write_strobe,
    output mem_address_ready, mem_data_ok, mem_read_data,
    input  protocol_error
  );
endinterface

// File: rtl/memory_request_arbiter_fifo.sv
// Order FIFO holding the source id of each accepted, not-yet-answered request.
module request_order_fifo
  import memory_arbiter_params::*;
#(
  parameter int DEPTH = OUTSTANDING_DEPTH_DEFAULT
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       push,
  input  logic       pop,
  input  source_id_t push_id,
  output source_id_t head_id,
  output logic       full,
  output logic       empty
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  source_id_t    slots [DEPTH];
  logic          do_push, do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head_id = slots[rd_ptr];

  // Payload needs no reset; only valid entries are ever read.
  always_ff @(posedge clock) begin
    if (do_push) slots[wr_ptr] <= push_id;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/memory_request_arbiter.sv
// Two-requester SRAM-like port arbiter with in-order response routing.
// Optional ARBITER_ROUND_ROBIN_EN: alternate winner on contention instead of data-first.
module memory_request_arbiter
  import memory_arbiter_params::*;
#(
  parameter int OUTSTANDING_DEPTH = OUTSTANDING_DEPTH_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset_n,
  memory_request_arbiter_if.slave  bus
);
  memory_request_t inst_req, data_req, sel_req;
  arbiter_state_t  state;
  source_id_t      grant, sel_src, head_id;
  logic            fifo_full, fifo_empty;
  logic            active, handshake, pop, protocol_error_q;

  assign inst_req = '{request: bus.inst_request, write: bus.inst_write, size: bus.inst_size,
                      address: bus.inst_address, write_data: bus.inst_write_data,
                      write_strobe: bus.inst_write_strobe};
  assign data_req = '{request: bus.data_request, write: bus.data_write, size: bus.data_size,
                      address: bus.data_address, write_data: bus.data_write_data,
                      write_strobe: bus.data_write_strobe};

`ifdef ARBITER_ROUND_ROBIN_EN
  source_id_t last_grant;

  always_comb begin
    sel_src = grant;
    if (state == IDLE) begin
      if (bus.inst_request && bus.data_request)
        sel_src = (last_grant == SOURCE_INST) ? SOURCE_DATA : SOURCE_INST;
      else
        sel_src = bus.data_request ? SOURCE_DATA : SOURCE_INST;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)       last_grant <= SOURCE_INST;
    else if (handshake) last_grant <= sel_src;
  end
`else
  always_comb begin
    sel_src = grant;
    if (state == IDLE) sel_src = bus.data_request ? SOURCE_DATA : SOURCE_INST;
  end
`endif

  assign sel_req = (sel_src == SOURCE_DATA) ? data_req : inst_req;

  // Grant is combinational in IDLE; reset_n gating keeps every output low during reset.
  assign active    = reset_n & ((state == HOLD) | (sel_req.request & ~fifo_full));
  assign handshake = active & bus.mem_address_ready;
  assign pop       = reset_n & bus.mem_data_ok & ~fifo_empty;

  assign bus.mem_request      = active;
  assign bus.mem_write        = active & sel_req.write;
  assign bus.mem_size         = active ? sel_req.size : '0;
  assign bus.mem_address      = active ? sel_req.address : '0;
  assign bus.mem_write_data   = active ? sel_req.write_data : '0;
  assign bus.mem_write_strobe = active ? sel_req.write_strobe : '0;

  assign bus.inst_address_ready = handshake & (sel_src == SOURCE_INST);
  assign bus.data_address_ready = handshake & (sel_src == SOURCE_DATA);
  assign bus.inst_data_ok       = pop & (head_id == SOURCE_INST);
  assign bus.data_data_ok       = pop & (head_id == SOURCE_DATA);
  assign bus.inst_read_data     = reset_n ? bus.mem_read_data : '0;
  assign bus.data_read_data     = reset_n ? bus.mem_read_data : '0;
  assign bus.protocol_error     = protocol_error_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      grant            <= SOURCE_INST;
      protocol_error_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (active && !bus.mem_address_ready) begin
          grant <= sel_src;
          state <= HOLD;
        end
        HOLD: if (bus.mem_address_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (bus.mem_data_ok && fifo_empty) protocol_error_q <= 1'b1;
    end
  end

  request_order_fifo #(.DEPTH(OUTSTANDING_DEPTH)) u_order_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (handshake),
    .pop     (pop),
    .push_id (sel_src),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );
endmodule
